// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ requesters,
// with per-packet locking, a gap timeout on stalled locks and lost-frame detection.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int BUSY_WAIT = 8,
    parameter int GAP_WAIT  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [9*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [8:0]        tx_data,
    output logic              tx_send,
    input  logic              tx_busy,
    output logic [2:0]        grant_id,
    output logic              active,
    output logic              err_lost,
    output logic              err_gap
);

    localparam int GW = $clog2(GAP_WAIT + 1);
    localparam int BW = $clog2(BUSY_WAIT + 1);

    typedef enum logic [1:0] {ARB, SEND, WAIT_BUSY, WAIT_DONE} state_t;

    state_t         state;
    logic [2:0]     pointer;
    logic           lock;
    logic [GW-1:0]  gap_cnt;
    logic [BW-1:0]  busy_cnt;

    logic           found;
    logic [2:0]     winner;
    logic [8:0]     win_data;
    logic           win_last;

    // Index k steps past base, wrapping at NREQ (NREQ need not be a power of two).
    function automatic logic [2:0] rr_index(input logic [2:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return s[2:0];
    endfunction

    // NOTE: every signal gets a default at the top of the block so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        found    = 1'b0;
        winner   = grant_id;
        win_data = '0;
        win_last = 1'b0;
        if (state == ARB) begin
            if (lock) begin
                for (int i = 0; i < NREQ; i++)
                    if (req_valid[i] && grant_id == 3'(i)) found = 1'b1;
            end else begin
                for (int k = 0; k < NREQ; k++)
                    for (int i = 0; i < NREQ; i++)
                        if (!found && req_valid[i] && rr_index(pointer, k) == 3'(i)) begin
                            found  = 1'b1;
                            winner = 3'(i);
                        end
            end
        end
        for (int i = 0; i < NREQ; i++)
            if (winner == 3'(i)) begin
                win_data = req_data[9*i +: 9];
                win_last = req_last[i];
            end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++)
            if (found && winner == 3'(i)) req_ready[i] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every register in the
    // block updates from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB;
            pointer  <= '0;
            lock     <= 1'b0;
            gap_cnt  <= '0;
            busy_cnt <= '0;
            tx_data  <= '0;
            tx_send  <= 1'b0;
            grant_id <= '0;
            active   <= 1'b0;
            err_lost <= 1'b0;
            err_gap  <= 1'b0;
        end else begin
            tx_send <= 1'b0;
            err_gap <= 1'b0;
            case (state)
                ARB: begin
                    if (found) begin
                        // An accept beats a gap timeout landing in the same cycle.
                        tx_data  <= win_data;
                        grant_id <= winner;
                        lock     <= ~win_last;
                        active   <= 1'b1;
                        tx_send  <= 1'b1;
                        gap_cnt  <= '0;
                        state    <= SEND;
                    end else if (lock) begin
                        if (gap_cnt == GW'(GAP_WAIT - 1)) begin
                            lock    <= 1'b0;
                            err_gap <= 1'b1;
                            pointer <= rr_index(grant_id, 1);
                            gap_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                SEND: begin
                    busy_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (busy_cnt == BW'(BUSY_WAIT - 1)) begin
                        err_lost <= 1'b1;
                        lock     <= 1'b0;
                        active   <= 1'b0;
                        pointer  <= rr_index(grant_id, 1);
                        state    <= ARB;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        active <= 1'b0;
                        if (!lock) pointer <= rr_index(grant_id, 1);
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues drive words, a transmitter
// stub answers tx_send, and a monitor scores each frame against expected grants.
module tb_uart_tx_arbiter;

    localparam int NREQ      = 4;
    localparam int BUSY_WAIT = 8;
    localparam int GAP_WAIT  = 16;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [9*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [8:0]        tx_data;
    logic              tx_send;
    logic              tx_busy;
    logic [2:0]        grant_id;
    logic              active;
    logic              err_lost;
    logic              err_gap;

    uart_tx_arbiter #(.NREQ(NREQ), .BUSY_WAIT(BUSY_WAIT), .GAP_WAIT(GAP_WAIT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
        .grant_id(grant_id), .active(active),
        .err_lost(err_lost), .err_gap(err_gap)
    );

    typedef struct {
        logic [2:0] id;
        logic [8:0] data;
        logic       last;
    } word_t;

    typedef struct {
        logic [2:0] id;
        logic [8:0] data;
    } frame_t;

    word_t  stim_q[$];
    frame_t exp_q[$];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    // Monitor bookkeeping
    logic [NREQ-1:0] acc_mask = '0;
    bit   lat_pending = 0;
    bit   prev_send = 0, prev_active = 0, prev_busy = 0, prev_gap = 0, prev_lost = 0;
    logic [8:0] prev_data = '0;
    int   proto_viol = 0;
    int   last_send_cyc = -1;
    int   min_space = 1000000;
    int   active_fall_cyc = 0, busy_fall_cyc = 0;
    int   gap_hi = 0, gap_delta = -1;
    logic [NREQ-1:0] gap_ready = '0;
    int   lost_delta = -1;

    // Transmitter stub
    int busy_len = 3;
    bit stub_busy = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_word(input int id, input logic [8:0] data, input logic last);
        word_t w;
        w.id = 3'(id); w.data = data; w.last = last;
        stim_q.push_back(w);
    endtask

    task automatic expect_frame(input int id, input logic [8:0] data);
        frame_t f;
        f.id = 3'(id); f.data = data;
        exp_q.push_back(f);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0 || active || stub_busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(n < 400, {name, "_timeout"}, n, 400);
        @(negedge clk);
    endtask

    // Requester model: each requester presents its oldest queued word until accepted.
    initial begin
        req_valid = '0; req_data = '0; req_last = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++)
                if (acc_mask[i])
                    for (int j = 0; j < stim_q.size(); j++)
                        if (stim_q[j].id == 3'(i)) begin
                            stim_q.delete(j);
                            break;
                        end
            acc_mask = '0;
            req_valid = '0; req_data = '0; req_last = '0;
            for (int i = 0; i < NREQ; i++)
                for (int j = 0; j < stim_q.size(); j++)
                    if (stim_q[j].id == 3'(i)) begin
                        req_valid[i]        = 1'b1;
                        req_data[9*i +: 9]  = stim_q[j].data;
                        req_last[i]         = stim_q[j].last;
                        break;
                    end
        end
    end

    // Transmitter stub: busy rises the cycle after tx_send and holds busy_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_send && busy_len > 0) begin
                stub_busy = 1;
                @(posedge clk);
                #1 tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 tx_busy = 1'b0;
                stub_busy = 0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        frame_t e;
        forever begin
            @(negedge clk);
            if (lat_pending) check(tx_send == 1'b1, "accept_to_send_latency", int'(tx_send), 1);
            lat_pending = |(req_valid & req_ready);
            acc_mask    = req_valid & req_ready;
            if (((req_ready & (req_ready - 1'b1)) != 0) || ((req_ready & ~req_valid) != 0) ||
                (req_ready != 0 && active) || (tx_send && prev_send) ||
                (active && prev_active && tx_data != prev_data))
                proto_viol++;
            if (tx_send) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_send", int'(grant_id), 0);
                end else begin
                    e = exp_q.pop_front();
                    check(grant_id == e.id, "grant_id", int'(grant_id), int'(e.id));
                    check(tx_data == e.data, "tx_data", int'(tx_data), int'(e.data));
                    check(active == 1'b1, "active_in_send", int'(active), 1);
                end
                if (last_send_cyc >= 0 && cyc - last_send_cyc < min_space) min_space = cyc - last_send_cyc;
                last_send_cyc = cyc;
            end
            if (err_gap) begin
                gap_hi++;
                if (!prev_gap) begin
                    gap_delta = cyc - active_fall_cyc;
                    gap_ready = req_ready;
                end
            end
            if (err_lost && !prev_lost) lost_delta = cyc - last_send_cyc;
            if (prev_busy && !tx_busy) busy_fall_cyc = cyc;
            if (prev_active && !active) active_fall_cyc = cyc;
            prev_send = tx_send; prev_active = active; prev_busy = tx_busy;
            prev_gap = err_gap; prev_lost = err_lost; prev_data = tx_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        check(req_ready == '0, "reset_req_ready", int'(req_ready), 0);
        check(tx_data == '0 && tx_send == 1'b0, "reset_tx", int'({tx_send, tx_data}), 0);
        check(grant_id == '0 && active == 1'b0, "reset_grant_active", int'({active, grant_id}), 0);
        check(err_lost == 1'b0 && err_gap == 1'b0, "reset_err", int'({err_lost, err_gap}), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Single requester
        busy_len = 3;
        @(negedge clk);
        push_word(0, 9'h157, 1'b1);
        expect_frame(0, 9'h157);
        n = 0;
        do begin @(negedge clk); n++; end while (!req_valid[0] && n < 20);
        check(req_ready == 4'b0001, "single_ready_same_cycle", int'(req_ready), 1);
        wait_idle("single");
        check(active_fall_cyc - busy_fall_cyc == 1, "single_active_fall", active_fall_cyc - busy_fall_cyc, 1);

        // Fairness: all four valid, all last=1
        do_reset();
        busy_len = 10;
        min_space = 1000000;
        last_send_cyc = -1;
        push_word(0, 9'h0A0, 1'b1);
        push_word(1, 9'h0B1, 1'b1);
        push_word(2, 9'h0C2, 1'b1);
        push_word(3, 9'h0D3, 1'b1);
        push_word(0, 9'h0E0, 1'b1);
        expect_frame(0, 9'h0A0);
        expect_frame(1, 9'h0B1);
        expect_frame(2, 9'h0C2);
        expect_frame(3, 9'h0D3);
        expect_frame(0, 9'h0E0);
        wait_idle("fair");
        check(min_space >= 12, "fair_send_spacing", min_space, 12);

        // Lock: req0 packet of three words while req2 waits
        do_reset();
        busy_len = 4;
        push_word(0, 9'h011, 1'b0);
        push_word(0, 9'h022, 1'b0);
        push_word(0, 9'h033, 1'b1);
        push_word(2, 9'h1AA, 1'b1);
        expect_frame(0, 9'h011);
        expect_frame(0, 9'h022);
        expect_frame(0, 9'h033);
        expect_frame(2, 9'h1AA);
        wait_idle("lock");

        // Gap timeout: req0 holds the lock then goes silent while req1 waits
        do_reset();
        busy_len = 4;
        gap_hi = 0;
        gap_delta = -1;
        push_word(0, 9'h0F5, 1'b0);
        push_word(1, 9'h12C, 1'b1);
        expect_frame(0, 9'h0F5);
        expect_frame(1, 9'h12C);
        wait_idle("gap");
        check(gap_delta == GAP_WAIT, "gap_timeout_cycle", gap_delta, GAP_WAIT);
        check(gap_hi == 1, "gap_pulse_width", gap_hi, 1);
        check(gap_ready == 4'b0010, "gap_next_grant", int'(gap_ready), 2);

        // Lost frame: busy never rises
        do_reset();
        busy_len = 0;
        lost_delta = -1;
        push_word(0, 9'h1C3, 1'b1);
        push_word(1, 9'h03C, 1'b1);
        expect_frame(0, 9'h1C3);
        expect_frame(1, 9'h03C);
        wait_idle("lost");
        check(lost_delta >= BUSY_WAIT && lost_delta <= BUSY_WAIT + 1, "lost_timeout_cycle", lost_delta, BUSY_WAIT);
        check(err_lost == 1'b1, "lost_sticky", int'(err_lost), 1);

        // Async reset in WAIT_DONE, then service resumes with pointer=0
        busy_len = 20;
        push_word(2, 9'h0F0, 1'b1);
        expect_frame(2, 9'h0F0);
        n = 0;
        do begin @(negedge clk); n++; end while (!tx_send && n < 50);
        check(n < 50, "reset_test_send_timeout", n, 50);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check(active == 1'b0, "async_reset_active", int'(active), 0);
        check(grant_id == 3'd0, "async_reset_grant", int'(grant_id), 0);
        check(tx_data == 9'd0, "async_reset_tx_data", int'(tx_data), 0);
        check(err_lost == 1'b0, "async_reset_err_lost", int'(err_lost), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (stub_busy && n < 50) begin @(negedge clk); n++; end
        busy_len = 3;
        push_word(3, 9'h1F3, 1'b1);
        push_word(1, 9'h101, 1'b1);
        expect_frame(1, 9'h101);
        expect_frame(3, 9'h1F3);
        wait_idle("post_reset");

        check(proto_viol == 0, "handshake_protocol", proto_viol, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
